// File: rtl/uart_rcv.sv
// 8N1 serial receiver: 2-flop synchronized RX, mid-bit sampling, LSB first,
// ready/clear handshake with framing-error and overrun flags.
module uart_rcv #(
    parameter int BAUD_DIV = 2604
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RX,
    input  logic       clr_rdy,
    output logic [7:0] rx_data,
    output logic       rdy,
    output logic       frm_err,
    output logic       ovr_err
);

    localparam logic [11:0] BIT_RELOAD  = 12'(BAUD_DIV - 1);
    localparam logic [11:0] HALF_RELOAD = 12'(BAUD_DIV / 2 - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t      state_q;
    logic        rx_s1_q;
    logic        rx_s2_q;
    logic        rx_prev_q;
    logic [11:0] baud_q;
    logic [3:0]  bit_q;
    logic [7:0]  shift_q;

    logic tick;
    logic fall;

    assign tick = (state_q != IDLE) && (baud_q == 12'd0);
    assign fall = rx_prev_q & ~rx_s2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
            baud_q    <= 12'd0;
            bit_q     <= 4'd0;
            shift_q   <= 8'd0;
            rx_data   <= 8'd0;
            rdy       <= 1'b0;
            frm_err   <= 1'b0;
            ovr_err   <= 1'b0;
        end else begin
            rx_s1_q   <= RX;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;

            // A good-byte load below overrides this clear in the same cycle.
            if (clr_rdy) begin
                rdy     <= 1'b0;
                ovr_err <= 1'b0;
            end

            if (state_q != IDLE) begin
                baud_q <= tick ? BIT_RELOAD : baud_q - 12'd1;
            end

            case (state_q)
                IDLE: begin
                    if (fall) begin
                        baud_q  <= HALF_RELOAD;
                        frm_err <= 1'b0;
                        state_q <= START;
                    end
                end
                START: begin
                    if (tick) begin
                        if (rx_s2_q) begin
                            state_q <= IDLE;
                        end else begin
                            bit_q   <= 4'd0;
                            state_q <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        shift_q <= {rx_s2_q, shift_q[7:1]};
                        bit_q   <= bit_q + 4'd1;
                        if (bit_q == 4'd7) begin
                            state_q <= STOP;
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        state_q <= IDLE;
                        if (rx_s2_q) begin
                            rx_data <= shift_q;
                            rdy     <= 1'b1;
                            if (rdy && !clr_rdy) begin
                                ovr_err <= 1'b1;
                            end
                        end else begin
                            frm_err <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rcv.sv
// Directed bench for uart_rcv: frame table plus hand-written latency, glitch,
// simultaneous clear/load and mid-frame reset sequences.
module tb_uart_rcv;

    localparam int B   = 64;
    localparam int LAT = 9 * B + B / 2 + 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       RX;
    logic       clr_rdy;
    logic [7:0] rx_data;
    logic       rdy;
    logic       frm_err;
    logic       ovr_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] data;
        logic       stop_ok;
        logic       clr_after;
        logic       exp_rdy;
        logic [7:0] exp_data;
        logic       exp_frm;
        logic       exp_ovr;
    } vec_t;

    vec_t tbl[8];

    always #5 clk = ~clk;

    uart_rcv #(.BAUD_DIV(B)) dut (
        .clk    (clk),
        .rst    (rst),
        .RX     (RX),
        .clr_rdy(clr_rdy),
        .rx_data(rx_data),
        .rdy    (rdy),
        .frm_err(frm_err),
        .ovr_err(ovr_err)
    );

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic r, input logic [7:0] d,
                             input logic f, input logic o);
        chk({tag, ".rdy"}, {7'd0, rdy}, {7'd0, r});
        chk({tag, ".rx_data"}, rx_data, d);
        chk({tag, ".frm_err"}, {7'd0, frm_err}, {7'd0, f});
        chk({tag, ".ovr_err"}, {7'd0, ovr_err}, {7'd0, o});
    endtask

    // Bad stop holds the line low for two bit times, then idles high one bit.
    task automatic send_frame(input logic [7:0] d, input logic stop_ok);
        @(negedge clk);
        RX = 1'b0;
        repeat (B) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            RX = d[i];
            repeat (B) @(negedge clk);
        end
        RX = stop_ok;
        repeat (B) @(negedge clk);
        if (!stop_ok) begin
            repeat (B) @(negedge clk);
            RX = 1'b1;
            repeat (B) @(negedge clk);
        end
    endtask

    task automatic pulse_clr(input string tag);
        @(negedge clk);
        clr_rdy = 1'b1;
        @(negedge clk);
        clr_rdy = 1'b0;
        chk({tag, ".clr_rdy"}, {7'd0, rdy}, 8'd0);
        chk({tag, ".clr_ovr"}, {7'd0, ovr_err}, 8'd0);
    endtask

    initial begin
        int cnt;

        tbl[0] = '{8'h67, 1'b1, 1'b0, 1'b1, 8'h67, 1'b0, 1'b0};
        tbl[1] = '{8'h73, 1'b1, 1'b1, 1'b1, 8'h73, 1'b0, 1'b1};
        tbl[2] = '{8'h3C, 1'b0, 1'b0, 1'b0, 8'h73, 1'b1, 1'b0};
        tbl[3] = '{8'h81, 1'b1, 1'b1, 1'b1, 8'h81, 1'b0, 1'b0};
        tbl[4] = '{8'h00, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
        tbl[5] = '{8'hFF, 1'b1, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b1};
        tbl[6] = '{8'h5A, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b1, 1'b0};
        tbl[7] = '{8'hC3, 1'b1, 1'b1, 1'b1, 8'hC3, 1'b0, 1'b0};

        rst     = 1'b1;
        RX      = 1'b1;
        clr_rdy = 1'b0;
        repeat (4) @(negedge clk);
        check_out("reset", 1'b0, 8'h00, 1'b0, 1'b0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Start-edge to rdy latency on a single 0x67.
        cnt = 0;
        fork
            send_frame(8'h67, 1'b1);
            begin
                @(negedge clk);
                while (cnt < LAT + 20) begin
                    @(posedge clk);
                    #1;
                    cnt++;
                    if (rdy) break;
                end
            end
        join
        checks++;
        if (cnt < LAT - 2 || cnt > LAT + 2) begin
            errors++;
            $display("FAIL latency: got %0d cycles, expected %0d +/-2", cnt, LAT);
        end
        check_out("good67", 1'b1, 8'h67, 1'b0, 1'b0);
        pulse_clr("good67");

        for (int i = 0; i < 8; i++) begin
            send_frame(tbl[i].data, tbl[i].stop_ok);
            check_out($sformatf("vec%0d", i), tbl[i].exp_rdy, tbl[i].exp_data,
                      tbl[i].exp_frm, tbl[i].exp_ovr);
            if (tbl[i].clr_after) pulse_clr($sformatf("vec%0d", i));
        end

        // Short low glitch must be rejected as a false start.
        @(negedge clk);
        RX = 1'b0;
        repeat (10) @(negedge clk);
        RX = 1'b1;
        repeat (2 * B) @(negedge clk);
        chk("glitch.rdy", {7'd0, rdy}, 8'd0);
        chk("glitch.frm_err", {7'd0, frm_err}, 8'd0);
        send_frame(8'hA5, 1'b1);
        check_out("afterglitch", 1'b1, 8'hA5, 1'b0, 1'b0);

        // clr_rdy coincides with the load of the second byte.
        pulse_clr("pre_simul");
        send_frame(8'h34, 1'b1);
        check_out("simul_first", 1'b1, 8'h34, 1'b0, 1'b0);
        fork
            send_frame(8'h12, 1'b1);
            begin
                @(negedge clk);
                repeat (LAT - 1) @(posedge clk);
                @(negedge clk);
                clr_rdy = 1'b1;
                @(negedge clk);
                clr_rdy = 1'b0;
            end
        join
        check_out("simul", 1'b1, 8'h12, 1'b0, 1'b0);

        send_frame(8'h99, 1'b1);
        check_out("ovr99", 1'b1, 8'h99, 1'b0, 1'b1);
        send_frame(8'h3C, 1'b0);
        check_out("frm_keep", 1'b1, 8'h99, 1'b1, 1'b1);

        // Asynchronous reset in the middle of data bit 4.
        fork
            send_frame(8'hFF, 1'b1);
            begin
                @(negedge clk);
                repeat (5 * B + B / 2) @(negedge clk);
                #2;
                rst = 1'b1;
                #1;
                check_out("rst_async", 1'b0, 8'h00, 1'b0, 1'b0);
                repeat (3) @(negedge clk);
                rst = 1'b0;
            end
        join
        check_out("post_rst", 1'b0, 8'h00, 1'b0, 1'b0);
        send_frame(8'h55, 1'b1);
        check_out("after_rst", 1'b1, 8'h55, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
